fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end; replaces the PC register plus IF/ID latch pair of the 5-stage core.
- Generates PCs and drives a synchronous-read instruction ROM with one-cycle latency.
- Buffers returned instructions in a DEPTH-entry FIFO and presents them to the decode stage with valid/stall handshaking.
- Supports branch redirect with full flush of the FIFO and of any in-flight fetch.

Parameters:
- ADDR_W, 32, PC / ROM address width
- INST_W, 32, instruction width
- DEPTH, 4, fetch FIFO entries; power of two, at least 2
- RESET_PC, 0, PC value after reset
- PC_STEP, 4, PC increment per fetch

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- rom_addr_o  out  ADDR_W  ROM address (current PC register)
- rom_ce_o  out  1  ROM enable; high = fetch issued this cycle
- rom_data_i  in  INST_W  ROM data, valid the cycle after an issue
- branch_flag_i  in  1  redirect request from decode/execute
- branch_target_i  in  ADDR_W  redirect target PC
- stall_i  in  1  decode cannot accept the head instruction this cycle
- id_valid_o  out  1  head instruction valid
- id_pc_o  out  ADDR_W  PC of head instruction
- id_inst_o  out  INST_W  head instruction
- fifo_count_o  out  log2(DEPTH)+1  occupied FIFO entries

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC; FIFO empty; fifo_count_o=0; in-flight flag req_v=0.
  - id_valid_o=0; id_pc_o=0; id_inst_o=0; rom_ce_o=0; state=IDLE.
- FSM, two states:
  - IDLE: rom_ce_o=0. Entered at reset; moves to RUN on the first clock edge after rst deasserts. Instruction fetch cannot start in the same cycle reset is released.
  - RUN: normal operation.
- Pop: pop = id_valid_o & ~stall_i. The head entry is removed at the clock edge.
- Issue (RUN only):
  - issue = ~branch_flag_i & ((count + req_v - pop) < DEPTH).
  - rom_ce_o = issue; rom_addr_o = pc.
  - On issue: pc <= pc + PC_STEP (modulo 2^ADDR_W, wraps silently); req_v <= 1; req_pc <= pc. Otherwise req_v <= 0.
  - The credit rule guarantees returning data always has a free slot, so there is no overflow path.
- Return: when req_v=1 at a cycle, rom_data_i is pushed with req_pc at the edge ending that cycle.
  - Latency: address at cycle N -> data latched into the FIFO at the end of N+1 -> visible on id_* at N+2 if the FIFO was empty.
- Simultaneous push and pop: allowed at any count, including count=DEPTH-1 and count=DEPTH; count is unchanged.
- Output presentation:
  - id_pc_o and id_inst_o show the head entry whenever id_valid_o=1.
  - When the FIFO is empty: id_valid_o=0 and id_pc_o/id_inst_o hold their last values (0 after reset).
  - No bypass from ROM to outputs.
- Redirect (branch_flag_i=1 in RUN):
  - At the edge: FIFO emptied (count=0); req_v cleared, so the in-flight return is discarded; pc <= branch_target_i.
  - rom_ce_o=0 that cycle. The target is issued the next cycle, subject to the normal credit rule.
  - The pop condition is ignored in a redirect cycle.
  - branch_flag_i in IDLE is ignored.
  - Redirect has priority over stall; consecutive redirect cycles keep only the last target.
- Pointers: read and write pointers wrap modulo DEPTH. count distinguishes full from empty.
- Reset mid-operation: all state returns to reset values immediately (asynchronously). The in-flight return is discarded; rom_data_i is not sampled after reset.

Test Plan:
- Reset release, stall_i=0, ROM returns addr-derived data:
  - rom_ce_o=0 in the first cycle.
  - Then rom_addr_o = 0x0, 0x4, 0x8…, one per cycle.
  - id_valid_o rises 2 cycles after the first issue with id_pc_o=0x0; thereafter one instruction per cycle, PCs consecutive.
- Hold stall_i=1 from the start (DEPTH=4):
  - Exactly 4 issues (0x0–0xC); fifo_count_o reaches 4; rom_ce_o stays 0 and pc stays at 0x10.
  - Release stall_i: entries pop in order 0x0, 0x4, 0x8, 0xC; issue resumes at 0x10 in the first pop cycle.
- Full FIFO with stall_i=0 steady-state: count stays constant and throughput is 1/cycle with no gaps in id_pc_o.
- branch_flag_i=1, target 0x100, while the FIFO holds 3 entries and a fetch is in flight:
  - Next cycle id_valid_o=0 and fifo_count_o=0; the in-flight data does not appear.
  - rom_addr_o=0x100 with rom_ce_o=1 the cycle after the redirect.
  - First valid output has id_pc_o=0x100.
- Redirect while stall_i=1 and the FIFO is full: flush occurs, stream restarts at the target, and no stale PC is ever presented.
- Assert rst=0 asynchronously mid-stream (between edges): all outputs go to reset values immediately; after release, fetch restarts at RESET_PC with the IDLE cycle.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC generation, one-cycle-latency ROM interface,
// DEPTH-entry instruction FIFO toward decode, and branch redirect with full flush.
module fetch_unit #(
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          INST_W   = 32,
  parameter int unsigned          DEPTH    = 4,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0,
  parameter logic [ADDR_W-1:0]    PC_STEP  = ADDR_W'(4),
  localparam int unsigned         PW       = $clog2(DEPTH),
  localparam int unsigned         CW       = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic              rom_ce_o,
  input  logic [INST_W-1:0] rom_data_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              stall_i,
  output logic              id_valid_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  output logic [CW-1:0]     fifo_count_o,
  output logic              dbg_state_o
);

  // Handshake: the head entry leaves the FIFO at a rising edge where
  // id_valid_o=1 and stall_i=0; a ROM issue is a cycle with rom_ce_o=1 and
  // its data must be presented on rom_data_i throughout the following cycle.

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic                req_v_q;
  logic [ADDR_W-1:0]   req_pc_q;
  logic [ADDR_W-1:0]   last_pc_q;
  logic [INST_W-1:0]   last_inst_q;
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q;
  logic [CW-1:0]       count_d;

  logic [ADDR_W-1:0]   mem_pc   [DEPTH];
  logic [INST_W-1:0]   mem_inst [DEPTH];

  logic                valid;
  logic                pop;
  logic                push;
  logic                redirect;
  logic                issue;
  logic [CW:0]         pending;

  always_comb begin
    valid    = (count_q != '0);
    pop      = valid & ~stall_i;
    redirect = (state_q == RUN) & branch_flag_i;
    push     = req_v_q & ~redirect;
    // Slots already promised: occupied entries plus the in-flight return,
    // minus the one leaving this edge. Issuing only below DEPTH means a
    // returning instruction always finds room.
    pending  = {1'b0, count_q} + (CW+1)'(req_v_q) - (CW+1)'(pop);
    issue    = (state_q == RUN) & ~branch_flag_i & (pending < (CW+1)'(DEPTH));
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      req_v_q     <= 1'b0;
      req_pc_q    <= '0;
      last_pc_q   <= '0;
      last_inst_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      if (valid) begin
        last_pc_q   <= mem_pc[rd_ptr_q];
        last_inst_q <= mem_inst[rd_ptr_q];
      end
      case (state_q)
        IDLE: begin
          state_q <= RUN;
          req_v_q <= 1'b0;
        end
        RUN: begin
          if (redirect) begin
            pc_q     <= branch_target_i;
            req_v_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
          end else begin
            req_v_q <= issue;
            if (issue) begin
              pc_q     <= pc_q + PC_STEP;
              req_pc_q <= pc_q;
            end
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr_q]   <= req_pc_q;
      mem_inst[wr_ptr_q] <= rom_data_i;
    end
  end

  assign rom_addr_o   = pc_q;
  assign rom_ce_o     = issue;
  assign id_valid_o   = valid;
  assign id_pc_o      = valid ? mem_pc[rd_ptr_q]   : last_pc_q;
  assign id_inst_o    = valid ? mem_inst[rd_ptr_q] : last_inst_q;
  assign fifo_count_o = count_q;
  assign dbg_state_o  = state_q;

endmodule
